// File: rtl/add_approx_pkg.sv
// -----------------------------------------------------------------------------
// add_approx_pkg
//   Shared definitions for the pipelined lower-part-OR (LOA) approximate adder.
//
//   CNT_W    width of the delivered-error counter.
//   clamp_k  limits a requested approximation depth to the configured maximum.
//   k_width  width of the k field/port for a given maximum depth (never 0).
//
//   The stage payload struct depends on the adder width, so it is declared
//   inside add_approx_pipe, where WIDTH is known. Packages cannot be
//   parameterised.
// -----------------------------------------------------------------------------
package add_approx_pkg;

  localparam int CNT_W = 16;

  // Depth requests above the configured maximum saturate rather than wrap.
  function automatic int unsigned clamp_k(input int unsigned k,
                                          input int unsigned max_k);
    return (k > max_k) ? max_k : k;
  endfunction

  // A zero-width port is illegal, so MAX_K = 0 still gets one bit.
  function automatic int unsigned k_width(input int unsigned max_k);
    return (max_k > 0) ? $clog2(max_k + 1) : 1;
  endfunction

endpackage

// File: rtl/add_approx_seg.sv
// -----------------------------------------------------------------------------
// add_approx_seg
//   One SEG-bit slice of a lower-part-OR approximate adder (combinational).
//   Slice bits whose global position is below k are the OR of the operands.
//   Those bits do not take part in the carry chain. The only exception is
//   bit k-1, whose AND becomes the carry into bit k. Bits at position k and
//   above form an ordinary ripple adder fed by cin.
//
// Ports
//   a, b       operand slices                     (SEG bits)
//   cin        carry from the slice below
//   k          clamped approximation depth        (KW bits)
//   seg_index  slice number; global bit = seg_index*SEG + j
//   sum        result slice                       (SEG bits)
//   cout       carry to the slice above
// -----------------------------------------------------------------------------
module add_approx_seg
  import add_approx_pkg::*;
#(
  parameter int SEG = 4,
  parameter int KW  = 3,
  parameter int IW  = 1
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  input  logic [KW-1:0]  k,
  input  logic [IW-1:0]  seg_index,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  always_comb begin
    logic        c;
    int unsigned pos;
    int unsigned kk;
    c   = cin;
    sum = '0;
    pos = 0;
    kk  = 32'(k);
    for (int j = 0; j < SEG; j++) begin
      pos = 32'(seg_index) * 32'(SEG) + 32'(j);
      if (pos < kk) begin
        // Approximate region: the carry chain is cut. Only the topmost
        // approximated bit seeds the carry into the exact upper part.
        sum[j] = a[j] | b[j];
        c      = (pos + 32'd1 == kk) ? (a[j] & b[j]) : 1'b0;
      end else begin
        sum[j] = a[j] ^ b[j] ^ c;
        c      = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
      end
    end
    cout = c;
  end

endmodule

// File: rtl/add_approx_pipe.sv
// -----------------------------------------------------------------------------
// add_approx_pipe
//   Pipelined lower-part-OR approximate adder with a runtime approximation
//   depth carried with each beat. The WIDTH-bit add is split into STAGES
//   slices of SEG = WIDTH/STAGES bits. Each slice is computed by an
//   add_approx_seg and then registered. The carry ripples from one register
//   bank to the next. The operands, k and the partial sum ride along with
//   the beat. Result latency is STAGES cycles. Throughput is one beat per
//   cycle while the output is drained.
//
//   Flow control uses one global advance (adv = ~out_valid | out_ready).
//   Every bank moves together, or every bank holds. Bubbles stay in place.
//
// Build option
//   `define ERR_MON_EN  adds a parallel exact adder in the same banks.
//     It drives err_abs and keeps the delivered-error statistics
//     err_max and err_cnt.
//   Without it, the three error outputs are tied to 0 and err_clr is
//   unused. The approximate sum and its timing are the same in both builds.
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   in_valid/in_ready   input handshake; a beat is taken when both are high
//   in_a, in_b          operands (WIDTH bits)
//   in_k                requested approximate LSB count; clamped to MAX_K
//   out_valid/out_ready output handshake
//   out_sum             approximate sum (WIDTH+1 bits; MSB = top carry)
//   err_clr             zero err_max/err_cnt next cycle (wins over update)
//   err_abs             |exact - approx| of the presented result
//   err_max             largest err_abs delivered since reset/clear
//   err_cnt             delivered results with err_abs != 0 (saturating)
// -----------------------------------------------------------------------------
module add_approx_pipe
  import add_approx_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int STAGES = 2,
  parameter  int MAX_K  = 4,
  localparam int KW     = k_width(MAX_K)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [KW-1:0]    in_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  input  logic             err_clr,
  output logic [WIDTH:0]   err_abs,
  output logic [WIDTH:0]   err_max,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int SEG = WIDTH / STAGES;
  localparam int IW  = (STAGES > 1) ? $clog2(STAGES) : 1;

  // Parameter sanity checks at elaboration time.
  if (WIDTH % STAGES != 0) begin : g_split_check
    $error("add_approx_pipe: WIDTH must be a multiple of STAGES");
  end
  if (MAX_K < 0 || MAX_K > WIDTH) begin : g_maxk_check
    $error("add_approx_pipe: MAX_K must lie in 0..WIDTH");
  end

  // Everything one beat carries between banks. sum/esum fill from the
  // bottom slice upward. carry/ecarry hold the carry out of the slice
  // most recently computed.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] sum;
`ifdef ERR_MON_EN
    logic             ecarry;
    logic [WIDTH-1:0] esum;
`endif
  } stage_t;

  logic          adv;
  logic [KW-1:0] k_in;
  stage_t        head;
  stage_t        last;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign k_in     = KW'(clamp_k(32'(in_k), MAX_K));

  // Payload presented to bank 0. The sum is empty and there is no carry.
  always_comb begin
    head       = '0;
    head.valid = in_valid;
    head.a     = in_a;
    head.b     = in_b;
    head.k     = k_in;
  end

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    stage_t         src;
    stage_t         stage_next;
    stage_t         stage_reg;
    logic [SEG-1:0] slice;
    logic           cout;

    if (gi == 0) begin : g_src_head
      assign src = head;
    end else begin : g_src_prev
      assign src = g_stage[gi-1].stage_reg;
    end

    add_approx_seg #(
      .SEG (SEG),
      .KW  (KW),
      .IW  (IW)
    ) u_seg (
      .a         (src.a[gi*SEG +: SEG]),
      .b         (src.b[gi*SEG +: SEG]),
      .cin       (src.carry),
      .k         (src.k),
      .seg_index (IW'(gi)),
      .sum       (slice),
      .cout      (cout)
    );

`ifdef ERR_MON_EN
    // Exact reference slice. It keeps its own carry chain, independent of k.
    logic [SEG:0] exact_seg;
    assign exact_seg = {1'b0, src.a[gi*SEG +: SEG]}
                     + {1'b0, src.b[gi*SEG +: SEG]}
                     + {{SEG{1'b0}}, src.ecarry};
`endif

    always_comb begin
      stage_next                     = src;
      stage_next.carry               = cout;
      stage_next.sum[gi*SEG +: SEG]  = slice;
`ifdef ERR_MON_EN
      stage_next.ecarry              = exact_seg[SEG];
      stage_next.esum[gi*SEG +: SEG] = exact_seg[SEG-1:0];
`endif
    end

    // Reset drops every beat in flight. There is no partial output.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_reg <= '0;
      end else if (adv) begin
        stage_reg <= stage_next;
      end
    end
  end

  assign last      = g_stage[STAGES-1].stage_reg;
  assign out_valid = last.valid;
  assign out_sum   = {last.carry, last.sum};

`ifdef ERR_MON_EN
  logic [WIDTH:0]   approx_val;
  logic [WIDTH:0]   exact_val;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   max_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             unused_tail;

  assign approx_val = {last.carry, last.sum};
  assign exact_val  = {last.ecarry, last.esum};

  // The approximation can land on either side of the exact sum. One example
  // is the carry seeded by bit k-1 when both operands have all low bits set.
  // So the magnitude is taken both ways.
  always_comb begin
    diff = '0;
    if (out_valid) begin
      diff = (exact_val >= approx_val) ? (exact_val - approx_val)
                                       : (approx_val - exact_val);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_reg <= '0;
      cnt_reg <= '0;
    end else if (err_clr) begin
      max_reg <= '0;
      cnt_reg <= '0;
    end else if (out_valid && out_ready) begin
      if (diff > max_reg) begin
        max_reg <= diff;
      end
      if (diff != '0 && cnt_reg != '1) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign err_abs     = diff;
  assign err_max     = max_reg;
  assign err_cnt     = cnt_reg;
  assign unused_tail = ^{last.a, last.b, last.k};
`else
  logic unused_tail;

  assign err_abs     = '0;
  assign err_max     = '0;
  assign err_cnt     = '0;
  assign unused_tail = ^{last.a, last.b, last.k, err_clr};
`endif

endmodule
